sdram_burst_responder: RTL and testbench
========================================

Name: sdram_burst_responder

Overview:
Avalon-MM burst slave that answers the SDRAM master port used by the register-file load/store engine. It fronts a single-port on-chip memory with 1-cycle read latency, which serves as an SDRAM stand-in or scratchpad. It accepts read and write bursts of up to 2^BURST_W-1 beats, converts each beat into one memory access, and returns read data in order with readdatavalid. One burst is in progress at a time.

Parameters:
DATA_W, 128, beat width in bits; equals the SDRAM data width.
ADDR_W, 32, Avalon address width; the address is in beat (word) units.
MEM_ADDR_W, 12, backing memory depth is 2^MEM_ADDR_W words.
BURST_W, 8, burstcount width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
avs_address  in  ADDR_W  burst start word address
avs_read  in  1  read command
avs_write  in  1  write command and beat strobe
avs_burstcount  in  BURST_W  beats in burst
avs_byteenable  in  DATA_W/8  write byte lanes
avs_writedata  in  DATA_W  write beat data
avs_waitrequest  out  1  command/beat not accepted
avs_readdata  out  DATA_W  read beat data
avs_readdatavalid  out  1  read beat valid
mem_addr  out  MEM_ADDR_W  memory address
mem_d  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe
mem_q  in  DATA_W  memory read data, valid 1 cycle after mem_re
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, avs_readdatavalid 0, avs_readdata 0, proto_err 0, beat counter 0, address register 0.
- All mem_* outputs are combinational from state and avs inputs. When no access occurs, they are 0.
- States: IDLE, RD_BURST, WR_BURST.
- Burst length: burstcount 0 is treated as 1.
- Addressing: mem_addr = low MEM_ADDR_W bits of the beat address. Upper address bits are ignored. The beat address increments modulo 2^MEM_ADDR_W, so a burst wraps at the top of memory.
- avs_waitrequest:
  - IDLE: 0.
  - WR_BURST: 0.
  - RD_BURST: 1.
- Read accepted (IDLE, avs_read=1) at cycle T:
  - mem_re=1 and mem_addr=address in cycle T.
  - Beat i is issued at T+i and appears as avs_readdata/avs_readdatavalid (registered from mem_q) at T+2+i.
  - If burstcount>1, go to RD_BURST with remaining=burstcount-1. RD_BURST issues one beat per cycle and returns to IDLE in the cycle it issues the last beat.
  - Read data cannot be back-pressured.
  - Beats still in flight continue to return after IDLE is re-entered. A new command accepted then does not disturb them.
- Write accepted (IDLE, avs_write=1) at cycle T:
  - Beat 0 is written in the same cycle: mem_we=1, mem_d=writedata, mem_be=byteenable.
  - If burstcount>1, go to WR_BURST with remaining=burstcount-1.
  - In WR_BURST, each cycle with avs_write=1 writes one beat at the next address and decrements remaining.
  - A cycle with avs_write=0 is a stall: no memory access, no change to the counter.
  - Return to IDLE after the last beat.
- Byteenable applies to writes only; it is ignored on reads.
- Simultaneous read and write in IDLE: the read wins. The write is dropped and proto_err is set.
- avs_read asserted while in WR_BURST: ignored, and proto_err is set.
- proto_err is sticky; only reset clears it.
- Reset mid-burst: return to IDLE immediately. In-flight read beats are discarded and readdatavalid goes low.

Decomposition:
- Shared package npu_avmm_pkg holds:
  - the state_t enum {IDLE, RD_BURST, WR_BURST};
  - a beats-per-RF-line constant (RF_DATA_W/SDRAM_DATA_W) shared with the load/store engine.
- The backing memory is a separate single-port RAM, npu_sp_ram (1-cycle read, per-byte write enable), instantiated by the parent and testbench, not inside this block.
- No other sub-module: the read-return pipeline stays inline.

Test Plan:
- Single read: preload mem[5]=A. Read addr 5, burstcount 1, accepted at T → readdatavalid only at T+2 with data A; waitrequest 0 again at T+1.
- 11-beat read burst at addr 0x10 (data=addr) → 11 consecutive valid beats from T+2, values 0x10..0x1A in order; waitrequest=1 for T+1..T+10.
- 11-beat write burst at addr 0x20 with write deasserted for 2 cycles after beat 3 → exactly 11 mem_we pulses; readback of 0x20..0x2A matches; no write during the stall.
- Write with byteenable=0x000F over a word of 0xFF.. → only the low 4 bytes change.
- Wrap: read burst of 4 at addr 2^MEM_ADDR_W-2 → addresses FFE, FFF, 000, 001. burstcount 0 behaves as 1 beat.
- read&write both high in IDLE → read serviced, no mem_we, proto_err=1 until rst_n. rst_n low mid-read burst → readdatavalid 0 next cycle, state IDLE.

Source files
------------

// File: rtl/npu_avmm_pkg.sv
// Shared Avalon-MM definitions for the NPU SDRAM path.
// The load/store engine and the burst responder both import this package,
// so the burst state encoding and the RF-line geometry stay in one place.
package npu_avmm_pkg;

    // Width of one SDRAM beat and of one register-file line.
    localparam int SDRAM_DATA_W = 128;
    localparam int RF_DATA_W    = 512;

    // Number of SDRAM beats needed to move one register-file line.
    localparam int BEATS_PER_RF_LINE = RF_DATA_W / SDRAM_DATA_W;

    // Burst responder command states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;

endpackage

// File: rtl/npu_sp_ram.sv
// Single-port on-chip RAM with one cycle of read latency and per-byte
// write enables. It backs the burst responder as an SDRAM stand-in and is
// instantiated next to the responder by the parent, not inside it.
module npu_sp_ram #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 12
) (
    input  logic                  clk,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     d,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_W-1:0]     q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Byte-lane writes and a registered read port; contents have no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= d[b*8 +: 8];
                end
            end
        end
        if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/sdram_burst_responder.sv
// Avalon-MM burst slave in front of a single-port memory with one cycle of
// read latency. Each burst beat becomes one memory access; read data comes
// back in order two cycles after the beat is issued. One burst at a time.
module sdram_burst_responder
    import npu_avmm_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 32,
    parameter int MEM_ADDR_W = 12,
    parameter int BURST_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [BURST_W-1:0]    avs_burstcount,
    input  logic [DATA_W/8-1:0]   avs_byteenable,
    input  logic [DATA_W-1:0]     avs_writedata,
    output logic                  avs_waitrequest,
    output logic [DATA_W-1:0]     avs_readdata,
    output logic                  avs_readdatavalid,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_d,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_W-1:0]     mem_q,
    output logic                  proto_err
);

    state_t                state;
    logic [BURST_W-1:0]    remaining;
    logic [MEM_ADDR_W-1:0] addr_reg;
    logic                  rd_pend;

    logic [MEM_ADDR_W-1:0] start_addr;
    logic [BURST_W-1:0]    first_remaining;
    logic                  addr_hi_unused;

    // Only the low address bits reach the memory; the rest wrap away.
    assign start_addr     = avs_address[MEM_ADDR_W-1:0];
    assign addr_hi_unused = ^avs_address[ADDR_W-1:MEM_ADDR_W];

    // Beats left after the first one; a burstcount of zero means one beat.
    assign first_remaining = (avs_burstcount == '0) ? '0
                                                    : avs_burstcount - BURST_W'(1);

    // Read bursts stream from the beat counter, so new commands wait.
    assign avs_waitrequest = (state == RD_BURST);

    // Memory strobes are decoded from state and the live Avalon inputs.
    always_comb begin
        mem_addr = '0;
        mem_d    = '0;
        mem_be   = '0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        case (state)
            IDLE: begin
                if (avs_read) begin
                    mem_re   = 1'b1;
                    mem_addr = start_addr;
                end else if (avs_write) begin
                    mem_we   = 1'b1;
                    mem_addr = start_addr;
                    mem_d    = avs_writedata;
                    mem_be   = avs_byteenable;
                end
            end
            RD_BURST: begin
                mem_re   = 1'b1;
                mem_addr = addr_reg;
            end
            WR_BURST: begin
                if (avs_write) begin
                    mem_we   = 1'b1;
                    mem_addr = addr_reg;
                    mem_d    = avs_writedata;
                    mem_be   = avs_byteenable;
                end
            end
            default: begin
            end
        endcase
    end

    // Burst FSM: tracks the next beat address, beats left and protocol errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            addr_reg  <= '0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (avs_read) begin
                        if (avs_write) begin
                            proto_err <= 1'b1;
                        end
                        if (first_remaining != '0) begin
                            state     <= RD_BURST;
                            remaining <= first_remaining;
                            addr_reg  <= start_addr + MEM_ADDR_W'(1);
                        end
                    end else if (avs_write) begin
                        if (first_remaining != '0) begin
                            state     <= WR_BURST;
                            remaining <= first_remaining;
                            addr_reg  <= start_addr + MEM_ADDR_W'(1);
                        end
                    end
                end
                RD_BURST: begin
                    addr_reg  <= addr_reg + MEM_ADDR_W'(1);
                    remaining <= remaining - BURST_W'(1);
                    if (remaining == BURST_W'(1)) begin
                        state <= IDLE;
                    end
                end
                WR_BURST: begin
                    if (avs_read) begin
                        proto_err <= 1'b1;
                    end
                    if (avs_write) begin
                        addr_reg  <= addr_reg + MEM_ADDR_W'(1);
                        remaining <= remaining - BURST_W'(1);
                        if (remaining == BURST_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read return pipeline: memory answers a cycle after mem_re, then the
    // beat is registered onto the Avalon side, independent of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend           <= 1'b0;
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= '0;
        end else begin
            rd_pend           <= mem_re;
            avs_readdatavalid <= rd_pend;
            if (rd_pend) begin
                avs_readdata <= mem_q;
            end
        end
    end

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Directed self-checking bench for sdram_burst_responder with an npu_sp_ram
// behind it. Expected values are hand-derived from the burst protocol.
module tb_sdram_burst_responder;

    localparam int DATA_W     = 128;
    localparam int ADDR_W     = 32;
    localparam int MEM_ADDR_W = 12;
    localparam int BURST_W    = 8;
    localparam int BE_W       = DATA_W / 8;

    localparam logic [DATA_W-1:0] WORD_A = 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C;

    logic                  clk;
    logic                  rst_n;
    logic [ADDR_W-1:0]     avs_address;
    logic                  avs_read;
    logic                  avs_write;
    logic [BURST_W-1:0]    avs_burstcount;
    logic [BE_W-1:0]       avs_byteenable;
    logic [DATA_W-1:0]     avs_writedata;
    logic                  avs_waitrequest;
    logic [DATA_W-1:0]     avs_readdata;
    logic                  avs_readdatavalid;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_d;
    logic [BE_W-1:0]       mem_be;
    logic                  mem_we;
    logic                  mem_re;
    logic [DATA_W-1:0]     mem_q;
    logic                  proto_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [DATA_W-1:0]     rv_data[$];
    int                    rv_cyc[$];
    logic [MEM_ADDR_W-1:0] we_addr[$];
    logic [MEM_ADDR_W-1:0] re_addr[$];

    sdram_burst_responder #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .MEM_ADDR_W (MEM_ADDR_W),
        .BURST_W    (BURST_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_burstcount    (avs_burstcount),
        .avs_byteenable    (avs_byteenable),
        .avs_writedata     (avs_writedata),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .mem_addr          (mem_addr),
        .mem_d             (mem_d),
        .mem_be            (mem_be),
        .mem_we            (mem_we),
        .mem_re            (mem_re),
        .mem_q             (mem_q),
        .proto_err         (proto_err)
    );

    npu_sp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (MEM_ADDR_W)
    ) u_ram (
        .clk  (clk),
        .addr (mem_addr),
        .d    (mem_d),
        .be   (mem_be),
        .we   (mem_we),
        .re   (mem_re),
        .q    (mem_q)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index, advanced on each active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Log returned beats and memory strobes mid-cycle for later checks.
    always @(negedge clk) begin
        if (avs_readdatavalid) begin
            rv_data.push_back(avs_readdata);
            rv_cyc.push_back(cyc);
        end
        if (mem_we) we_addr.push_back(mem_addr);
        if (mem_re) re_addr.push_back(mem_addr);
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                               input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                                 input int bc, input logic [BE_W-1:0] be,
                                 input logic [DATA_W-1:0] wd);
        avs_read       = rd;
        avs_write      = wr;
        avs_address    = addr;
        avs_burstcount = BURST_W'(bc);
        avs_byteenable = be;
        avs_writedata  = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clearLogs();
        rv_data.delete();
        rv_cyc.delete();
        we_addr.delete();
        re_addr.delete();
    endtask

    // Beat data used by pattern bursts: the wrapped memory word address.
    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input int i);
        logic [MEM_ADDR_W-1:0] w;
        w = a[MEM_ADDR_W-1:0] + MEM_ADDR_W'(i);
        return DATA_W'(w);
    endfunction

    task automatic doWriteBurst(input logic [ADDR_W-1:0] addr, input int n,
                                input int stall_at, input int stall_len);
        applyStimulus(1'b0, 1'b1, addr, n, '1, pat(addr, 0));
        tick();
        for (int i = 1; i < n; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    applyStimulus(1'b0, 1'b0, addr, n, '1, '0);
                    @(negedge clk);
                    checkOutput("stall_no_we", DATA_W'(mem_we), '0);
                    tick();
                end
            end
            applyStimulus(1'b0, 1'b1, addr, n, '1, pat(addr, i));
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0, 0, '0, '0);
    endtask

    task automatic doReadBurst(input logic [ADDR_W-1:0] addr, input int bc, output int t0);
        int beats;
        beats = (bc == 0) ? 1 : bc;
        applyStimulus(1'b1, 1'b0, addr, bc, '0, '0);
        t0 = cyc;
        @(negedge clk);
        checkOutput("rd_accept_re", DATA_W'(mem_re), 1);
        checkOutput("rd_accept_wait", DATA_W'(avs_waitrequest), 0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 0, '0, '0);
        for (int k = 1; k < beats; k++) begin
            @(negedge clk);
            checkOutput("rd_burst_wait", DATA_W'(avs_waitrequest), 1);
            tick();
        end
    endtask

    task automatic writeSingle(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d,
                               input logic [BE_W-1:0] be);
        applyStimulus(1'b0, 1'b1, addr, 1, be, d);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 0, '0, '0);
    endtask

    // Checks n logged beats returned at t0+2+i carrying pattern data.
    task automatic checkPatternReturn(input string tag, input int t0,
                                      input logic [ADDR_W-1:0] addr, input int n);
        checkOutput({tag, "_count"}, DATA_W'(rv_data.size()), DATA_W'(n));
        for (int i = 0; i < n && i < rv_data.size(); i++) begin
            checkOutput({tag, "_cyc"}, DATA_W'(rv_cyc[i]), DATA_W'(t0 + 2 + i));
            checkOutput({tag, "_data"}, rv_data[i], pat(addr, i));
        end
    endtask

    initial begin
        int t0;
        int t1;
        int n_before;

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 0, '0, '0);
        waitCycles(2);
        @(negedge clk);
        checkOutput("rst_wait", DATA_W'(avs_waitrequest), 0);
        checkOutput("rst_rdv", DATA_W'(avs_readdatavalid), 0);
        checkOutput("rst_rdata", avs_readdata, '0);
        checkOutput("rst_proto", DATA_W'(proto_err), 0);
        checkOutput("rst_mem_we", DATA_W'(mem_we), 0);
        checkOutput("rst_mem_re", DATA_W'(mem_re), 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] single read");
        writeSingle(32'd5, WORD_A, '1);
        tick();
        clearLogs();
        doReadBurst(32'd5, 1, t0);
        @(negedge clk);
        checkOutput("rd1_wait_t1", DATA_W'(avs_waitrequest), 0);
        checkOutput("rd1_rdv_t1", DATA_W'(avs_readdatavalid), 0);
        waitCycles(4);
        checkOutput("rd1_count", DATA_W'(rv_data.size()), 1);
        if (rv_data.size() > 0) begin
            checkOutput("rd1_cyc", DATA_W'(rv_cyc[0]), DATA_W'(t0 + 2));
            checkOutput("rd1_data", rv_data[0], WORD_A);
        end

        $display("[TB] 11-beat read then back-to-back single read");
        doWriteBurst(32'h10, 11, -1, 0);
        tick();
        clearLogs();
        doReadBurst(32'h10, 11, t0);
        doReadBurst(32'd5, 1, t1);
        waitCycles(5);
        checkOutput("rd11_t1", DATA_W'(t1), DATA_W'(t0 + 11));
        checkOutput("rd11_count", DATA_W'(rv_data.size()), 12);
        for (int i = 0; i < 11 && i < rv_data.size(); i++) begin
            checkOutput("rd11_cyc", DATA_W'(rv_cyc[i]), DATA_W'(t0 + 2 + i));
            checkOutput("rd11_data", rv_data[i], DATA_W'(32'h10 + i));
        end
        if (rv_data.size() > 11) begin
            checkOutput("b2b_cyc", DATA_W'(rv_cyc[11]), DATA_W'(t0 + 13));
            checkOutput("b2b_data", rv_data[11], WORD_A);
        end

        $display("[TB] stalled write burst");
        clearLogs();
        doWriteBurst(32'h20, 11, 4, 2);
        tick();
        checkOutput("wr_stall_we_count", DATA_W'(we_addr.size()), 11);
        for (int i = 0; i < 11 && i < we_addr.size(); i++) begin
            checkOutput("wr_stall_addr", DATA_W'(we_addr[i]), DATA_W'(32'h20 + i));
        end
        clearLogs();
        doReadBurst(32'h20, 11, t0);
        waitCycles(4);
        checkPatternReturn("wr_stall_rb", t0, 32'h20, 11);

        $display("[TB] byteenable");
        writeSingle(32'h40, '1, '1);
        writeSingle(32'h40, 128'h01020304_05060708_090A0B0C_11223344, 16'h000F);
        tick();
        clearLogs();
        doReadBurst(32'h40, 1, t0);
        waitCycles(4);
        checkOutput("be_count", DATA_W'(rv_data.size()), 1);
        if (rv_data.size() > 0)
            checkOutput("be_data", rv_data[0], 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_11223344);

        $display("[TB] wrap at top of memory");
        clearLogs();
        doWriteBurst(32'hABCD_0FFE, 4, -1, 0);
        tick();
        checkOutput("wrap_we_count", DATA_W'(we_addr.size()), 4);
        if (we_addr.size() == 4) begin
            checkOutput("wrap_we0", DATA_W'(we_addr[0]), 12'hFFE);
            checkOutput("wrap_we1", DATA_W'(we_addr[1]), 12'hFFF);
            checkOutput("wrap_we2", DATA_W'(we_addr[2]), 12'h000);
            checkOutput("wrap_we3", DATA_W'(we_addr[3]), 12'h001);
        end
        clearLogs();
        doReadBurst(32'h0000_1FFE, 4, t0);
        waitCycles(4);
        checkOutput("wrap_re_count", DATA_W'(re_addr.size()), 4);
        if (re_addr.size() == 4) begin
            checkOutput("wrap_re0", DATA_W'(re_addr[0]), 12'hFFE);
            checkOutput("wrap_re1", DATA_W'(re_addr[1]), 12'hFFF);
            checkOutput("wrap_re2", DATA_W'(re_addr[2]), 12'h000);
            checkOutput("wrap_re3", DATA_W'(re_addr[3]), 12'h001);
        end
        checkPatternReturn("wrap_rd", t0, 32'hFFE, 4);

        $display("[TB] burstcount zero");
        clearLogs();
        doReadBurst(32'd5, 0, t0);
        @(negedge clk);
        checkOutput("bc0_wait_t1", DATA_W'(avs_waitrequest), 0);
        waitCycles(4);
        checkOutput("bc0_count", DATA_W'(rv_data.size()), 1);
        if (rv_data.size() > 0) checkOutput("bc0_data", rv_data[0], WORD_A);

        $display("[TB] read and write together");
        checkOutput("proto_before", DATA_W'(proto_err), 0);
        clearLogs();
        applyStimulus(1'b1, 1'b1, 32'd5, 1, '1, 128'h1234);
        t0 = cyc;
        @(negedge clk);
        checkOutput("rw_no_we", DATA_W'(mem_we), 0);
        checkOutput("rw_re", DATA_W'(mem_re), 1);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 0, '0, '0);
        waitCycles(4);
        checkOutput("rw_count", DATA_W'(rv_data.size()), 1);
        if (rv_data.size() > 0) checkOutput("rw_data", rv_data[0], WORD_A);
        checkOutput("rw_proto", DATA_W'(proto_err), 1);
        waitCycles(5);
        checkOutput("rw_proto_sticky", DATA_W'(proto_err), 1);

        $display("[TB] reset mid read burst");
        clearLogs();
        applyStimulus(1'b1, 1'b0, 32'h10, 11, '0, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 0, '0, '0);
        waitCycles(3);
        @(negedge clk);
        checkOutput("mid_rdv_before", DATA_W'(avs_readdatavalid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rdv_rst", DATA_W'(avs_readdatavalid), 0);
        checkOutput("mid_wait_rst", DATA_W'(avs_waitrequest), 0);
        checkOutput("mid_proto_rst", DATA_W'(proto_err), 0);
        tick();
        @(negedge clk);
        checkOutput("mid_rdv_next", DATA_W'(avs_readdatavalid), 0);
        tick();
        rst_n = 1'b1;
        n_before = rv_data.size();
        waitCycles(6);
        checkOutput("mid_no_more_beats", DATA_W'(rv_data.size()), DATA_W'(n_before));
        checkOutput("mid_idle_wait", DATA_W'(avs_waitrequest), 0);
        clearLogs();
        doReadBurst(32'd5, 1, t0);
        waitCycles(4);
        checkOutput("post_rst_count", DATA_W'(rv_data.size()), 1);
        if (rv_data.size() > 0) checkOutput("post_rst_data", rv_data[0], WORD_A);

        $display("[TB] read during write burst");
        checkOutput("wrb_proto_before", DATA_W'(proto_err), 0);
        applyStimulus(1'b0, 1'b1, 32'h60, 3, '1, pat(32'h60, 0));
        tick();
        applyStimulus(1'b1, 1'b1, 32'h60, 3, '1, pat(32'h60, 1));
        @(negedge clk);
        checkOutput("wrb_no_re", DATA_W'(mem_re), 0);
        checkOutput("wrb_we", DATA_W'(mem_we), 1);
        checkOutput("wrb_wait", DATA_W'(avs_waitrequest), 0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h60, 3, '1, pat(32'h60, 2));
        tick();
        applyStimulus(1'b0, 1'b0, '0, 0, '0, '0);
        tick();
        checkOutput("wrb_proto", DATA_W'(proto_err), 1);
        clearLogs();
        doReadBurst(32'h60, 3, t0);
        waitCycles(4);
        checkPatternReturn("wrb_rb", t0, 32'h60, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
